// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for the serial_link transceiver:
//   - TX / RX state encodings (plain logic constants so the encodings are
//     fixed and readable in netlists / older tools)
//   - even_parity(): XOR of the low 'w' bits of a payload up to MAX_W wide
// -----------------------------------------------------------------------------
package serial_link_pkg;

    // Widest payload the link supports; parity helper operates on this width.
    localparam int MAX_W = 16;

    // TX states
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 2'd0;
    localparam tx_state_t TX_LOW  = 2'd1;
    localparam tx_state_t TX_HIGH = 2'd2;
    localparam tx_state_t TX_GAP  = 2'd3;

    // RX states
    typedef logic rx_state_t;
    localparam rx_state_t RX_WAIT  = 1'b0;
    localparam rx_state_t RX_SHIFT = 1'b1;

    // Even parity over the low w bits of v (bits at or above w are ignored).
    function automatic logic even_parity(input logic [MAX_W-1:0] v, input int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) p = p ^ v[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/serial_link_if.sv
// -----------------------------------------------------------------------------
// serial_link_if
// Controller-side bundle of the serial_link transceiver.
//   tx_send  : one-cycle request to transmit tx_data
//   tx_data  : payload, latched when tx_send is accepted
//   tx_busy  : high from accept until tx_done
//   tx_done  : one-cycle pulse at end of frame
//   rx_data  : last good received payload
//   rx_valid : one-cycle pulse, rx_data updated
//   rx_err   : one-cycle pulse on parity error or truncated frame
// Modports: master = game controller, slave = serial_link.
// -----------------------------------------------------------------------------
interface serial_link_if #(
    parameter int DATA_W = 7
);
    logic              tx_send;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;

    modport master (
        output tx_send, tx_data,
        input  tx_busy, tx_done, rx_data, rx_valid, rx_err
    );

    modport slave (
        input  tx_send, tx_data,
        output tx_busy, tx_done, rx_data, rx_valid, rx_err
    );
endinterface

// File: rtl/serial_link_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a single asynchronous input.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears both flops
//   i_d  : asynchronous input
//   o_q  : synchronised output (2 cycles latency)
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/serial_link.sv
// -----------------------------------------------------------------------------
// serial_link
// Full-duplex, source-synchronous serial transceiver. TX and RX are
// independent and share clk.
//   clk            : system clock
//   rst            : asynchronous active-high reset (aborts any frame)
//   ctl            : controller bundle (serial_link_if.slave)
//   o_link_clk_out : link clock to peer
//   o_link_dat_out : serial data to peer (LSB first, optional even parity last)
//   o_link_frm_out : frame-active to peer
//   i_link_clk_in  : link clock from peer (asynchronous)
//   i_link_dat_in  : serial data from peer (asynchronous)
//   i_link_frm_in  : frame-active from peer (asynchronous)
// Parameters: DATA_W payload bits (1..16), DIV clocks per link half period
// (>=4), PARITY_EN appends an even parity bit when 1.
// -----------------------------------------------------------------------------
module serial_link
    import serial_link_pkg::*;
#(
    parameter int DATA_W    = 7,
    parameter int DIV       = 16,
    parameter int PARITY_EN = 1
) (
    input  logic clk,
    input  logic rst,
    serial_link_if.slave ctl,
    output logic o_link_clk_out,
    output logic o_link_dat_out,
    output logic o_link_frm_out,
    input  logic i_link_clk_in,
    input  logic i_link_dat_in,
    input  logic i_link_frm_in
);
    localparam int NB    = DATA_W + PARITY_EN;
    localparam int CNT_W = $clog2(NB + 1);
    localparam int TC_W  = $clog2(2 * DIV);

    localparam logic [TC_W-1:0]  HALF_LAST = TC_W'(DIV - 1);
    localparam logic [TC_W-1:0]  GAP_LAST  = TC_W'(2 * DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(NB - 1);

    // ------------------------------------------------------------------ TX
    tx_state_t         r_tx_state;
    logic [TC_W-1:0]   r_tx_cnt;
    logic [CNT_W-1:0]  r_tx_idx;
    logic [NB-1:0]     r_tx_sh;     // bit currently on the wire is r_tx_sh[0]
    logic              r_tx_busy;
    logic              r_tx_done;
    logic [NB-1:0]     w_tx_frame;

    generate
        if (PARITY_EN != 0) begin : g_tx_par
            assign w_tx_frame = {even_parity(MAX_W'(ctl.tx_data), DATA_W), ctl.tx_data};
        end else begin : g_tx_nopar
            assign w_tx_frame = ctl.tx_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_sh    <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (ctl.tx_send) begin
                        r_tx_sh    <= w_tx_frame;
                        r_tx_idx   <= '0;
                        r_tx_cnt   <= '0;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= TX_LOW;
                    end
                end
                TX_LOW: begin
                    if (r_tx_cnt == HALF_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_HIGH;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TC_W'(1);
                    end
                end
                TX_HIGH: begin
                    if (r_tx_cnt == HALF_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == BIT_LAST) begin
                            r_tx_state <= TX_GAP;
                        end else begin
                            // Next bit moves onto the wire as the link clock falls.
                            r_tx_idx   <= r_tx_idx + CNT_W'(1);
                            r_tx_sh    <= r_tx_sh >> 1;
                            r_tx_state <= TX_LOW;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TC_W'(1);
                    end
                end
                TX_GAP: begin
                    if (r_tx_cnt == GAP_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_busy  <= 1'b0;
                        r_tx_done  <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TC_W'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Link outputs decode directly from registered state so reset clears them
    // immediately.
    logic w_tx_in_bit;
    assign w_tx_in_bit    = (r_tx_state == TX_LOW) || (r_tx_state == TX_HIGH);
    assign o_link_frm_out = w_tx_in_bit;
    assign o_link_clk_out = (r_tx_state == TX_HIGH);
    assign o_link_dat_out = w_tx_in_bit & r_tx_sh[0];
    assign ctl.tx_busy    = r_tx_busy;
    assign ctl.tx_done    = r_tx_done;

    // ------------------------------------------------------------------ RX
    logic w_clk_s;
    logic w_dat_s;
    logic w_frm_s;

    sync2 u_sync_clk (.clk(clk), .rst(rst), .i_d(i_link_clk_in), .o_q(w_clk_s));
    sync2 u_sync_dat (.clk(clk), .rst(rst), .i_d(i_link_dat_in), .o_q(w_dat_s));
    sync2 u_sync_frm (.clk(clk), .rst(rst), .i_d(i_link_frm_in), .o_q(w_frm_s));

    rx_state_t         r_rx_state;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [NB-1:0]     r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_err;
    logic              r_clk_d;
    logic              r_frm_d;

    logic w_clk_rise;
    logic w_frm_rise;
    logic w_frm_fall;
    assign w_clk_rise = w_clk_s & ~r_clk_d;
    assign w_frm_rise = w_frm_s & ~r_frm_d;
    assign w_frm_fall = ~w_frm_s & r_frm_d;

    // Frame as it would look with the current data bit dropped into slot
    // r_rx_cnt; lets the last bit be checked in the same cycle it arrives.
    logic [NB-1:0] w_rx_frame;
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_rx_slot
            assign w_rx_frame[gi] = (r_rx_cnt == CNT_W'(gi)) ? w_dat_s : r_rx_sh[gi];
        end
    endgenerate

    logic w_par_ok;
    generate
        if (PARITY_EN != 0) begin : g_rx_par
            assign w_par_ok = (w_rx_frame[NB-1] ==
                               even_parity(MAX_W'(w_rx_frame[DATA_W-1:0]), DATA_W));
        end else begin : g_rx_nopar
            assign w_par_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_WAIT;
            r_rx_cnt   <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_clk_d    <= 1'b0;
            r_frm_d    <= 1'b0;
        end else begin
            r_clk_d    <= w_clk_s;
            r_frm_d    <= w_frm_s;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                RX_WAIT: begin
                    // Only a fresh frm rise starts a frame, so clk edges after a
                    // completed frame but before frm falls are ignored.
                    if (w_frm_rise) begin
                        r_rx_cnt   <= '0;
                        r_rx_sh    <= '0;
                        r_rx_state <= RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    if (w_clk_rise && (r_rx_cnt == BIT_LAST)) begin
                        // Final bit wins over a simultaneous frm fall.
                        r_rx_state <= RX_WAIT;
                        if (w_par_ok) begin
                            r_rx_data  <= w_rx_frame[DATA_W-1:0];
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_rx_err <= 1'b1;
                        end
                    end else begin
                        if (w_clk_rise) begin
                            r_rx_sh  <= w_rx_frame;
                            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                        end
                        if (w_frm_fall) begin
                            r_rx_err   <= 1'b1;
                            r_rx_state <= RX_WAIT;
                        end
                    end
                end
                default: r_rx_state <= RX_WAIT;
            endcase
        end
    end

    assign ctl.rx_data  = r_rx_data;
    assign ctl.rx_valid = r_rx_valid;
    assign ctl.rx_err   = r_rx_err;

endmodule

// File: tb/tb_serial_link.sv
// -----------------------------------------------------------------------------
// tb_serial_link
// Directed bench for serial_link. Instance A: DATA_W=7, DIV=4, parity on,
// with link inputs selectable between loopback and bench-driven pins.
// Instance B: DATA_W=12, DIV=5, parity off, permanent loopback.
// -----------------------------------------------------------------------------
module tb_serial_link;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------- instance A
    serial_link_if #(.DATA_W(7)) a_if ();
    logic a_clk_o, a_dat_o, a_frm_o;
    logic a_clk_i, a_dat_i, a_frm_i;
    logic lb      = 1'b1;
    logic drv_clk = 1'b0;
    logic drv_dat = 1'b0;
    logic drv_frm = 1'b0;

    assign a_clk_i = lb ? a_clk_o : drv_clk;
    assign a_dat_i = lb ? a_dat_o : drv_dat;
    assign a_frm_i = lb ? a_frm_o : drv_frm;

    serial_link #(.DATA_W(7), .DIV(4), .PARITY_EN(1)) u_a (
        .clk            (clk),
        .rst            (rst),
        .ctl            (a_if),
        .o_link_clk_out (a_clk_o),
        .o_link_dat_out (a_dat_o),
        .o_link_frm_out (a_frm_o),
        .i_link_clk_in  (a_clk_i),
        .i_link_dat_in  (a_dat_i),
        .i_link_frm_in  (a_frm_i)
    );

    // ---------------------------------------------------------- instance B
    serial_link_if #(.DATA_W(12)) b_if ();
    logic b_clk, b_dat, b_frm;

    serial_link #(.DATA_W(12), .DIV(5), .PARITY_EN(0)) u_b (
        .clk            (clk),
        .rst            (rst),
        .ctl            (b_if),
        .o_link_clk_out (b_clk),
        .o_link_dat_out (b_dat),
        .o_link_frm_out (b_frm),
        .i_link_clk_in  (b_clk),
        .i_link_dat_in  (b_dat),
        .i_link_frm_in  (b_frm)
    );

    // ------------------------------------------------- pulse scoreboards
    int         a_vcnt = 0;
    int         a_ecnt = 0;
    logic [6:0] a_vlog [8];
    int         b_vcnt = 0;
    int         b_ecnt = 0;

    always @(negedge clk) begin
        if (a_if.rx_valid === 1'b1) begin
            if (a_vcnt < 8) a_vlog[a_vcnt] <= a_if.rx_data;
            a_vcnt <= a_vcnt + 1;
            $display("rx A valid data=%0h", a_if.rx_data);
        end
        if (a_if.rx_err === 1'b1) begin
            a_ecnt <= a_ecnt + 1;
            $display("rx A err");
        end
        if (b_if.rx_valid === 1'b1) begin
            b_vcnt <= b_vcnt + 1;
            $display("rx B valid data=%0h", b_if.rx_data);
        end
        if (b_if.rx_err === 1'b1) b_ecnt <= b_ecnt + 1;
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send on A; counts cycles with tx_busy high (bounded), optionally pokes
    // tx_send again at busy cycle 'poke'. done = tx_done in first non-busy cycle.
    task automatic send_a(input logic [6:0] d, input int poke, output int cyc, output logic done);
        @(negedge clk);
        a_if.tx_data = d;
        a_if.tx_send = 1'b1;
        @(negedge clk);
        a_if.tx_send = 1'b0;
        cyc = 0;
        while (a_if.tx_busy === 1'b1 && cyc < 1000) begin
            cyc++;
            if (cyc == poke) begin
                a_if.tx_send = 1'b1;
                a_if.tx_data = 7'h33;
            end else begin
                a_if.tx_send = 1'b0;
            end
            @(negedge clk);
        end
        a_if.tx_send = 1'b0;
        done = a_if.tx_done;
        $display("tx A data=%0h busy_cycles=%0d done=%0b", d, cyc, done);
    endtask

    // Drive a frame onto A's link inputs: nb bits of 'bits', LSB first,
    // half period of 4 system clocks, then drop frm.
    task automatic drive_frame(input logic [15:0] bits, input int nb);
        @(negedge clk);
        drv_frm = 1'b1;
        drv_clk = 1'b0;
        for (int i = 0; i < nb; i++) begin
            drv_dat = bits[i];
            repeat (4) @(negedge clk);
            drv_clk = 1'b1;
            repeat (4) @(negedge clk);
            drv_clk = 1'b0;
        end
        repeat (4) @(negedge clk);
        drv_frm = 1'b0;
        drv_dat = 1'b0;
        repeat (10) @(negedge clk);
        $display("drive A bits=%0h nb=%0d", bits, nb);
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int   cyc;
        logic done;
        int   v_snap;
        int   e_snap;

        a_if.tx_send = 1'b0;
        a_if.tx_data = '0;
        b_if.tx_send = 1'b0;
        b_if.tx_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",     a_if.tx_busy,  0);
        chk("rst_done",     a_if.tx_done,  0);
        chk("rst_lclk",     a_clk_o,       0);
        chk("rst_ldat",     a_dat_o,       0);
        chk("rst_lfrm",     a_frm_o,       0);
        chk("rst_rxvalid",  a_if.rx_valid, 0);
        chk("rst_rxerr",    a_if.rx_err,   0);
        chk("rst_rxdata",   a_if.rx_data,  0);
        chk("rst_b_rxdata", b_if.rx_data,  0);
        rst = 1'b0;

        // Loopback 7'h55: NB=8 -> 8*2*4 + 2*4 = 72 busy cycles
        send_a(7'h55, 0, cyc, done);
        chk("t1_busy_cycles", cyc, 72);
        chk("t1_done", done, 1);
        @(negedge clk);
        chk("t1_done_one_cycle", a_if.tx_done, 0);
        repeat (3) @(negedge clk);
        chk("t1_vcnt",   a_vcnt, 1);
        chk("t1_vdata",  a_vlog[0], 7'h55);
        chk("t1_rxdata", a_if.rx_data, 7'h55);
        chk("t1_ecnt",   a_ecnt, 0);

        // Back-to-back with a mid-frame tx_send that must be ignored
        send_a(7'h01, 20, cyc, done);
        chk("t2a_busy_cycles", cyc, 72);
        send_a(7'h7F, 0, cyc, done);
        chk("t2b_busy_cycles", cyc, 72);
        repeat (4) @(negedge clk);
        chk("t2_vcnt",   a_vcnt, 3);
        chk("t2_vdata0", a_vlog[1], 7'h01);
        chk("t2_vdata1", a_vlog[2], 7'h7F);
        chk("t2_ecnt",   a_ecnt, 0);

        // Driven RX: 7'h03 (parity 0) with parity bit inverted -> 8'h83
        lb = 1'b0;
        drive_frame(16'h0083, 8);
        chk("t3_ecnt",   a_ecnt, 1);
        chk("t3_vcnt",   a_vcnt, 3);
        chk("t3_rxdata", a_if.rx_data, 7'h7F);

        // Truncated frame (3 bits), then good 7'h2A (parity 1 -> 8'hAA)
        drive_frame(16'h0005, 3);
        chk("t4_trunc_ecnt", a_ecnt, 2);
        chk("t4_trunc_vcnt", a_vcnt, 3);
        drive_frame(16'h00AA, 8);
        chk("t4_vcnt",   a_vcnt, 4);
        chk("t4_vdata",  a_vlog[3], 7'h2A);
        chk("t4_rxdata", a_if.rx_data, 7'h2A);
        chk("t4_ecnt",   a_ecnt, 2);

        // Reset during bit 4 of 7'h5A (bit 4 = 1); bit 4 spans busy cycles 33..40
        lb = 1'b1;
        @(negedge clk);
        a_if.tx_data = 7'h5A;
        a_if.tx_send = 1'b1;
        @(negedge clk);
        a_if.tx_send = 1'b0;
        repeat (35) @(negedge clk);
        chk("t5_pre_busy", a_if.tx_busy, 1);
        chk("t5_pre_frm",  a_frm_o, 1);
        chk("t5_pre_dat",  a_dat_o, 1);
        v_snap = a_vcnt;
        e_snap = a_ecnt;
        #1 rst = 1'b1;
        #1;
        chk("t5_async_busy",   a_if.tx_busy,  0);
        chk("t5_async_lfrm",   a_frm_o,       0);
        chk("t5_async_ldat",   a_dat_o,       0);
        chk("t5_async_lclk",   a_clk_o,       0);
        chk("t5_async_rxdata", a_if.rx_data,  0);
        chk("t5_async_rxerr",  a_if.rx_err,   0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_no_done", a_if.tx_done, 0);
        send_a(7'h10, 0, cyc, done);
        chk("t5_busy_cycles", cyc, 72);
        chk("t5_done", done, 1);
        repeat (4) @(negedge clk);
        chk("t5_vcnt",   a_vcnt, v_snap + 1);
        chk("t5_vdata",  a_vlog[v_snap], 7'h10);
        chk("t5_ecnt",   a_ecnt, e_snap);

        // Instance B loopback 12'hA5C: NB=12 -> 12*2*5 + 2*5 = 130 busy cycles
        @(negedge clk);
        b_if.tx_data = 12'hA5C;
        b_if.tx_send = 1'b1;
        @(negedge clk);
        b_if.tx_send = 1'b0;
        cyc = 0;
        while (b_if.tx_busy === 1'b1 && cyc < 1000) begin
            cyc++;
            @(negedge clk);
        end
        $display("tx B data=a5c busy_cycles=%0d done=%0b", cyc, b_if.tx_done);
        chk("t6_busy_cycles", cyc, 130);
        chk("t6_done", b_if.tx_done, 1);
        repeat (4) @(negedge clk);
        chk("t6_vcnt",   b_vcnt, 1);
        chk("t6_rxdata", b_if.rx_data, 12'hA5C);
        chk("t6_ecnt",   b_ecnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
